mmc1_mapper: RTL and testbench

- MMC1 (SxROM) cartridge mapper controller, between the CPU/PPU bus front ends and the ROM arbiter.
- Decodes serial mapper-register writes from the CPU into PRG and CHR bank state.
- Translates CPU PRG addresses and PPU CHR addresses into flat 21-bit offsets for the arbiter's promaddr/cromaddr inputs.
- Reports nametable mirroring and PRG-RAM enable.

---
 rtl/mmc1_pkg.sv | 26 ++
 rtl/mmc1_shift.sv | 60 ++++++
 rtl/mmc1_mapper.sv | 102 ++++++++++
 tb/tb_mmc1_mapper.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mmc1_pkg.sv
// Shared constants for the MMC1 (SxROM) mapper: register-select codes, PRG bank
// modes, mirroring codes and the control register reset value.
package mmc1_pkg;

  // Register targeted by a committing write, taken from cpuaddr[14:13]
  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_CHR0 = 2'd1;
  localparam logic [1:0] SEL_CHR1 = 2'd2;
  localparam logic [1:0] SEL_PRG  = 2'd3;

  // PRG banking modes, ctrl[3:2]
  localparam logic [1:0] PRG_MODE_32K_A    = 2'd0;
  localparam logic [1:0] PRG_MODE_32K_B    = 2'd1;
  localparam logic [1:0] PRG_MODE_FIX_LOW  = 2'd2;
  localparam logic [1:0] PRG_MODE_FIX_HIGH = 2'd3;

  // Nametable mirroring, ctrl[1:0]
  localparam logic [1:0] MIRROR_ONE_LOW  = 2'd0;
  localparam logic [1:0] MIRROR_ONE_HIGH = 2'd1;
  localparam logic [1:0] MIRROR_VERT     = 2'd2;
  localparam logic [1:0] MIRROR_HORZ     = 2'd3;

  // Power-up / bit-7 reset forces PRG mode 3 (last bank fixed high)
  localparam logic [4:0] CTRL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_shift.sv
// MMC1 serial load port: 5-bit shift register and write counter. Emits a one-cycle
// commit with the assembled value on the fifth accepted serial write.
// Optional MMC1_CONSEC_FILTER_EN drops serial writes on the cputick right after a
// cputick that carried a write (the read-modify-write double store of real MMC1).
module mmc1_shift
  import mmc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cputick,
  input  logic       wstb,
  input  logic       data_bit,
  input  logic       reset_bit,
  output logic       clear,
  output logic       commit,
  output logic [4:0] value
);

  logic [4:0] shift_q;
  logic [2:0] cnt_q;
  logic       ser_ok;

`ifdef MMC1_CONSEC_FILTER_EN
  logic prev_wstb_q;

  // Remember whether the most recent CPU bus cycle carried a mapper write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_wstb_q <= 1'b0;
    end else if (cputick) begin
      prev_wstb_q <= wstb;
    end
  end

  assign ser_ok = wstb & ~reset_bit & ~prev_wstb_q;
`else
  logic unused_cputick;
  assign unused_cputick = cputick;
  assign ser_ok = wstb & ~reset_bit;
`endif

  assign clear  = wstb & reset_bit;
  assign value  = {data_bit, shift_q[4:1]};
  assign commit = ser_ok & (cnt_q == 3'd4);

  // Shift in LSB-first; any bit-7 write or a commit restarts the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 5'd0;
      cnt_q   <= 3'd0;
    end else if (clear || commit) begin
      shift_q <= 5'd0;
      cnt_q   <= 3'd0;
    end else if (ser_ok) begin
      shift_q <= value;
      cnt_q   <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1 (SxROM) mapper: decodes serial CPU writes into bank registers and maps
// CPU PRG / PPU CHR addresses to flat ROM offsets for the arbiter.
// Build option: MMC1_CONSEC_FILTER_EN (consecutive-write filter in mmc1_shift).
module mmc1_mapper
  import mmc1_pkg::*;
#(
  parameter int unsigned PRG_W = 21,
  parameter int unsigned CHR_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cputick,
  input  logic [15:0]      cpuaddr,
  input  logic [7:0]       cpudata,
  input  logic             cpuwr,
  input  logic [7:0]       prgbanks,
  input  logic [13:0]      ppuaddr,
  output logic [PRG_W-1:0] promaddr,
  output logic [CHR_W-1:0] cromaddr,
  output logic [1:0]       mirror,
  output logic             wramen
);

  logic       wstb;
  logic       clear;
  logic       commit;
  logic [4:0] value;
  logic [4:0] ctrl_q, chr0_q, chr1_q, prg_q;
  logic [7:0] last_bank;
  logic [7:0] prg_bank;
  logic [21:0] prom_full;
  logic [16:0] crom_full;
  logic       unused_bits;

  assign wstb = cputick & cpuwr & cpuaddr[15];

  mmc1_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .cputick   (cputick),
    .wstb      (wstb),
    .data_bit  (cpudata[0]),
    .reset_bit (cpudata[7]),
    .clear     (clear),
    .commit    (commit),
    .value     (value)
  );

  // Bank registers: bit-7 reset only touches ctrl; a commit loads one register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_RESET;
      chr0_q <= 5'd0;
      chr1_q <= 5'd0;
      prg_q  <= 5'd0;
    end else if (clear) begin
      ctrl_q <= ctrl_q | CTRL_RESET;
    end else if (commit) begin
      unique case (cpuaddr[14:13])
        SEL_CTRL: ctrl_q <= value;
        SEL_CHR0: chr0_q <= value;
        SEL_CHR1: chr1_q <= value;
        SEL_PRG:  prg_q  <= value;
        default:  ;
      endcase
    end
  end

  assign last_bank = (prgbanks == 8'd0) ? 8'd0 : prgbanks - 8'd1;

  // 16 KiB PRG bank for the half of 0x8000-0xFFFF selected by cpuaddr[14]
  always_comb begin
    prg_bank = 8'd0;
    unique case (ctrl_q[3:2])
      PRG_MODE_32K_A,
      PRG_MODE_32K_B:    prg_bank = {4'd0, prg_q[3:1], cpuaddr[14]};
      PRG_MODE_FIX_LOW:  prg_bank = cpuaddr[14] ? {4'd0, prg_q[3:0]} : 8'd0;
      PRG_MODE_FIX_HIGH: prg_bank = cpuaddr[14] ? last_bank : {4'd0, prg_q[3:0]};
      default:           prg_bank = 8'd0;
    endcase
  end

  // CHR offset: one 8 KiB bank (chr0 with bit 0 ignored) or two 4 KiB banks
  always_comb begin
    crom_full = 17'd0;
    if (ctrl_q[4]) begin
      crom_full = {(ppuaddr[12] ? chr1_q : chr0_q), ppuaddr[11:0]};
    end else begin
      crom_full = {chr0_q[4:1], ppuaddr[12:0]};
    end
  end

  // No modulo here: the arbiter wraps offsets by the actual ROM size
  assign prom_full = {prg_bank, cpuaddr[13:0]};
  assign promaddr  = PRG_W'(prom_full);
  assign cromaddr  = CHR_W'(crom_full);
  assign mirror    = ctrl_q[1:0];
  assign wramen    = ~prg_q[4];

  assign unused_bits = ^{cpudata[6:1], ppuaddr[13]};

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper: expected outputs are queued when a probe is
// driven and compared by a monitor on the falling edge.
module tb_mmc1_mapper;

  logic        clk;
  logic        rst_n;
  logic        cputick;
  logic [15:0] cpuaddr;
  logic [7:0]  cpudata;
  logic        cpuwr;
  logic [7:0]  prgbanks;
  logic [13:0] ppuaddr;
  logic [20:0] promaddr;
  logic [20:0] cromaddr;
  logic [1:0]  mirror;
  logic        wramen;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [20:0] prom;
    logic [20:0] crom;
    logic [1:0]  mir;
    logic        wram;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  mmc1_mapper #(
    .PRG_W (21),
    .CHR_W (21)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cputick  (cputick),
    .cpuaddr  (cpuaddr),
    .cpudata  (cpudata),
    .cpuwr    (cpuwr),
    .prgbanks (prgbanks),
    .ppuaddr  (ppuaddr),
    .promaddr (promaddr),
    .cromaddr (cromaddr),
    .mirror   (mirror),
    .wramen   (wramen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Compare queued expectations against the DUT away from the rising edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check_eq({cur.tag, ".prom"}, 32'(promaddr), 32'(cur.prom));
      check_eq({cur.tag, ".crom"}, 32'(cromaddr), 32'(cur.crom));
      check_eq({cur.tag, ".mirror"}, 32'(mirror), 32'(cur.mir));
      check_eq({cur.tag, ".wramen"}, 32'(wramen), 32'(cur.wram));
    end
  end

  // Entered and left at posedge+1
  task automatic probe(input string tag, input logic [15:0] ca, input logic [13:0] pa,
                       input logic [20:0] prom, input logic [20:0] crom,
                       input logic [1:0] mir, input logic wram);
    exp_t e;
    cputick = 1'b0;
    cpuwr   = 1'b0;
    cpuaddr = ca;
    ppuaddr = pa;
    e.tag = tag; e.prom = prom; e.crom = crom; e.mir = mir; e.wram = wram;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // One write cputick followed by one idle cputick
  task automatic tick_write(input logic [15:0] a, input logic [7:0] d);
    cpuaddr = a; cpudata = d; cputick = 1'b1; cpuwr = 1'b1;
    @(posedge clk); #1;
    cpuwr = 1'b0;
    @(posedge clk); #1;
    cputick = 1'b0;
  endtask

  task automatic serial_write(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) tick_write(a, {7'd0, v[i]});
  endtask

  // Two write cputicks back to back, then an idle cputick
  task automatic write_b2b(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
    cpuaddr = a; cpudata = d0; cputick = 1'b1; cpuwr = 1'b1;
    @(posedge clk); #1;
    cpudata = d1;
    @(posedge clk); #1;
    cpuwr = 1'b0;
    @(posedge clk); #1;
    cputick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cputick = 1'b0; cpuwr = 1'b0; cpuaddr = 16'h8000;
    cpudata = 8'h00; prgbanks = 8'd8; ppuaddr = 14'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    probe("rst_lo", 16'h8000, 14'h0000, 21'h00000, 21'h0000, 2'd0, 1'b1);
    probe("rst_hi", 16'hC000, 14'h0000, 21'h1C000, 21'h0000, 2'd0, 1'b1);

    serial_write(16'h8000, 5'h0E);
    probe("ctrl0e", 16'hC000, 14'h0000, 21'h1C000, 21'h0000, 2'd2, 1'b1);

    serial_write(16'hE000, 5'h05);
    probe("m3_prg5", 16'h8123, 14'h0000, 21'h14123, 21'h0000, 2'd2, 1'b1);

    serial_write(16'h8000, 5'h08);
    probe("m2_lo", 16'h8123, 14'h0000, 21'h00123, 21'h0000, 2'd0, 1'b1);
    probe("m2_hi", 16'hC123, 14'h0000, 21'h14123, 21'h0000, 2'd0, 1'b1);

    serial_write(16'h8000, 5'h10);
    serial_write(16'hA000, 5'h03);
    serial_write(16'hC000, 5'h06);
    probe("chr4k_lo", 16'h8123, 14'h0456, 21'h10123, 21'h3456, 2'd0, 1'b1);
    probe("chr4k_hi", 16'hC123, 14'h1456, 21'h14123, 21'h6456, 2'd0, 1'b1);

    serial_write(16'h8000, 5'h00);
    probe("chr8k", 16'h8123, 14'h1456, 21'h10123, 21'h3456, 2'd0, 1'b1);

    serial_write(16'hE000, 5'h15);
    probe("wram_off", 16'h8123, 14'h1456, 21'h10123, 21'h3456, 2'd0, 1'b0);

    // Partial sequence discarded by a bit-7 write
    for (int i = 0; i < 3; i++) tick_write(16'h8000, 8'h01);
    tick_write(16'h8000, 8'h80);
    probe("midrst_hi", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd0, 1'b0);
    probe("midrst_lo", 16'h8123, 14'h1456, 21'h14123, 21'h3456, 2'd0, 1'b0);
    serial_write(16'h8000, 5'h0F);
    probe("after_rst", 16'h8123, 14'h1456, 21'h14123, 21'h3456, 2'd3, 1'b0);

    // Writes below 0x8000 must not shift or commit
    serial_write(16'h6000, 5'h00);
    probe("low_ign", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd3, 1'b0);
    serial_write(16'h8000, 5'h0E);
    probe("low_clean", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd2, 1'b0);

    // Last-bank boundaries
    prgbanks = 8'd0;
    probe("banks0", 16'hC000, 14'h1456, 21'h00000, 21'h3456, 2'd2, 1'b0);
    prgbanks = 8'd32;
    probe("banks32", 16'hC000, 14'h1456, 21'h7C000, 21'h3456, 2'd2, 1'b0);
    prgbanks = 8'd8;

    // Back-to-back serial writes: bits 1,1 (b2b) then 0,1,0
    write_b2b(16'h8000, 8'h01, 8'h01);
    tick_write(16'h8000, 8'h00);
    tick_write(16'h8000, 8'h01);
    tick_write(16'h8000, 8'h00);
`ifdef MMC1_CONSEC_FILTER_EN
    // Second bit dropped: only four bits in, nothing committed yet
    probe("consec", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd2, 1'b0);
    tick_write(16'h8000, 8'h80);
    probe("consec_rst", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd2, 1'b0);
`else
    // All five bits accepted: ctrl=0x0B, mode 2
    probe("consec", 16'hC000, 14'h1456, 21'h14000, 21'h3456, 2'd3, 1'b0);
    tick_write(16'h8000, 8'h80);
    probe("consec_rst", 16'hC000, 14'h1456, 21'h1C000, 21'h3456, 2'd3, 1'b0);
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
